// File: rtl/alu_issue_seq.sv
// Sequential issue front-end for the external combinational ALU: accepts an instruction,
// reads two operands from an 8x16 register file, drives the ALU from registers and writes back.
module alu_issue_seq #(
   parameter int NREG = 8,
   parameter int W    = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          instr_valid,
   input  logic [19:0]   instr,
   output logic          instr_ready,
   input  logic          wr_en,
   input  logic [2:0]    wr_addr,
   input  logic [W-1:0]  wr_data,
   input  logic [2:0]    rd_addr,
   output logic [W-1:0]  rd_data,
   output logic [W-1:0]  alu_valA,
   output logic [W-1:0]  alu_valB,
   output logic [3:0]    alu_aluop,
   output logic [3:0]    alu_shift,
   output logic          alu_sub,
   output logic          alu_lr,
   input  logic [W-1:0]  alu_result,
   input  logic [3:0]    alu_cc,
   output logic [3:0]    cc_q,
   output logic          done
);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      CAPTURE
   } state_t;

   state_t        state;
   logic [19:0]   instr_q;
   logic [W-1:0]  regs [NREG];

   logic [3:0]    f_aluop;
   logic [2:0]    f_rd;
   logic [2:0]    f_ra;
   logic [2:0]    f_rb;
   logic [3:0]    f_shift;
   logic          f_sub;
   logic          f_lr;
   logic          f_wb;

   logic [W-1:0]  op_a;
   logic [W-1:0]  op_b;
   logic          wb_fire;
   logic          ext_write;

   assign f_aluop = instr_q[19:16];
   assign f_rd    = instr_q[15:13];
   assign f_ra    = instr_q[12:10];
   assign f_rb    = instr_q[9:7];
   assign f_shift = instr_q[6:3];
   assign f_sub   = instr_q[2];
   assign f_lr    = instr_q[1];
   assign f_wb    = instr_q[0];

   assign rd_data = regs[rd_addr];

   // A same-cycle external write to an operand register is forwarded into the issued operand.
   always_comb begin
      op_a = regs[f_ra];
      op_b = regs[f_rb];
      if (wr_en && (wr_addr == f_ra)) begin
         op_a = wr_data;
      end
      if (wr_en && (wr_addr == f_rb)) begin
         op_b = wr_data;
      end
   end

   // ALU writeback has priority over an external write to the same register.
   assign wb_fire   = (state == CAPTURE) && f_wb;
   assign ext_write = wr_en && !(wb_fire && (wr_addr == f_rd));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) begin
            regs[i] <= '0;
         end
      end else begin
         if (ext_write) begin
            regs[wr_addr] <= wr_data;
         end
         if (wb_fire) begin
            regs[f_rd] <= alu_result;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         instr_q     <= '0;
         instr_ready <= 1'b1;
         done        <= 1'b0;
         cc_q        <= '0;
         alu_valA    <= '0;
         alu_valB    <= '0;
         alu_aluop   <= '0;
         alu_shift   <= '0;
         alu_sub     <= 1'b0;
         alu_lr      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (instr_valid && instr_ready) begin
                  instr_q     <= instr;
                  instr_ready <= 1'b0;
                  state       <= ISSUE;
               end
            end
            ISSUE: begin
               alu_valA  <= op_a;
               alu_valB  <= op_b;
               alu_aluop <= f_aluop;
               alu_shift <= f_shift;
               alu_sub   <= f_sub;
               alu_lr    <= f_lr;
               state     <= CAPTURE;
            end
            CAPTURE: begin
               cc_q        <= alu_cc;
               done        <= 1'b1;
               instr_ready <= 1'b1;
               state       <= IDLE;
            end
            default: begin
               instr_ready <= 1'b1;
               state       <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_issue_seq.sv
// Self-checking bench for alu_issue_seq: a stand-in ALU drives alu_result/alu_cc, a register
// model plus scoreboard queue predict operands, condition codes and writebacks.
module tb_alu_issue_seq;

   typedef struct {
      logic [2:0]  rd;
      logic        wb;
      logic [15:0] res;
      logic [3:0]  cc;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        instr_valid;
   logic [19:0] instr;
   logic        instr_ready;
   logic        wr_en;
   logic [2:0]  wr_addr;
   logic [15:0] wr_data;
   logic [2:0]  rd_addr;
   logic [15:0] rd_data;
   logic [15:0] alu_valA;
   logic [15:0] alu_valB;
   logic [3:0]  alu_aluop;
   logic [3:0]  alu_shift;
   logic        alu_sub;
   logic        alu_lr;
   logic [15:0] alu_result;
   logic [3:0]  alu_cc;
   logic [3:0]  cc_q;
   logic        done;

   int          n_checks = 0;
   int          n_pass = 0;
   int          done_count = 0;
   int          cyc = 0;
   logic [15:0] mregs [8];
   exp_t        sb [$];

   alu_issue_seq #(.NREG(8), .W(16)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .instr_valid (instr_valid),
      .instr       (instr),
      .instr_ready (instr_ready),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .rd_addr     (rd_addr),
      .rd_data     (rd_data),
      .alu_valA    (alu_valA),
      .alu_valB    (alu_valB),
      .alu_aluop   (alu_aluop),
      .alu_shift   (alu_shift),
      .alu_sub     (alu_sub),
      .alu_lr      (alu_lr),
      .alu_result  (alu_result),
      .alu_cc      (alu_cc),
      .cc_q        (cc_q),
      .done        (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Stand-in ALU; returns {cc = {N,Z,C,V}, result}.
   function automatic logic [19:0] alu_fn(input logic [3:0] op, input logic [15:0] a,
                                          input logic [15:0] b, input logic [3:0] sh,
                                          input logic s, input logic l);
      logic [16:0] t;
      logic [15:0] r;
      logic        c;
      logic        v;
      t = '0;
      r = '0;
      c = 1'b0;
      v = 1'b0;
      case (op)
         4'd0: begin
            t = s ? ({1'b0, a} + {1'b0, ~b} + 17'd1) : ({1'b0, a} + {1'b0, b});
            r = t[15:0];
            c = t[16];
            v = s ? ((a[15] != b[15]) && (r[15] != a[15])) : ((a[15] == b[15]) && (r[15] != a[15]));
         end
         4'd1: r = a & b;
         4'd2: r = l ? (a << sh) : (a >> sh);
         4'd3: r = a | b;
         4'd4: r = a ^ b;
         4'd7: r = ~(a & b);
         4'd8: r = a | ~b;
         4'd9: begin
            t = {1'b0, b} + {1'b0, ~a} + 17'd1;
            r = t[15:0];
            c = t[16];
         end
         default: begin
            t = {1'b0, a} + {1'b0, b[14:0], 1'b0};
            r = t[15:0];
            c = t[16];
         end
      endcase
      return {r[15], (r == 16'h0000), c, v, r};
   endfunction

   assign {alu_cc, alu_result} = alu_fn(alu_aluop, alu_valA, alu_valB, alu_shift, alu_sub, alu_lr);

   function automatic logic [19:0] mk(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] ra,
                                      input logic [2:0] rb, input logic [3:0] sh, input logic s,
                                      input logic l, input logic wb);
      return {op, rd, ra, rb, sh, s, l, wb};
   endfunction

   // Scoreboard consumer: every done pulse retires the oldest expected instruction.
   always @(negedge clk) begin
      exp_t x;
      if (done) begin
         done_count = done_count + 1;
         n_checks++;
         if (sb.size() == 0) begin
            $display("[TB] FAIL done_unexpected: got done=1 want no pending instruction");
         end else begin
            x = sb.pop_front();
            if (cc_q !== x.cc) $display("[TB] FAIL cc_q: got %b want %b", cc_q, x.cc);
            else n_pass++;
            if (x.wb) mregs[x.rd] = x.res;
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout want completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic write_reg(input logic [2:0] addr, input logic [15:0] data);
      wr_en = 1'b1; wr_addr = addr; wr_data = data;
      @(posedge clk); #1;
      wr_en = 1'b0;
      mregs[addr] = data;
   endtask

   // Runs one instruction end to end; wr_phase 1 writes during ISSUE, 2 during CAPTURE.
   task automatic run_instr(input logic [19:0] ins, input int wr_phase,
                            input logic [2:0] waddr, input logic [15:0] wdata);
      logic [15:0] a;
      logic [15:0] b;
      logic [19:0] e;
      exp_t        x;
      instr_valid = 1'b1;
      instr = ins;
      @(negedge clk);
      n_checks++; if (instr_ready !== 1'b1) $display("[TB] FAIL ready_idle: got %0b want 1", instr_ready); else n_pass++;
      @(posedge clk); #1;
      instr_valid = 1'b0;
      instr = 20'($urandom);
      a = mregs[ins[12:10]];
      b = mregs[ins[9:7]];
      if (wr_phase == 1) begin
         wr_en = 1'b1; wr_addr = waddr; wr_data = wdata;
         if (waddr == ins[12:10]) a = wdata;
         if (waddr == ins[9:7]) b = wdata;
         mregs[waddr] = wdata;
      end
      e = alu_fn(ins[19:16], a, b, ins[6:3], ins[2], ins[1]);
      x.rd = ins[15:13]; x.wb = ins[0]; x.res = e[15:0]; x.cc = e[19:16];
      sb.push_back(x);
      @(negedge clk);
      n_checks++; if (instr_ready !== 1'b0) $display("[TB] FAIL ready_issue: got %0b want 0", instr_ready); else n_pass++;
      n_checks++; if (done !== 1'b0) $display("[TB] FAIL done_issue: got %0b want 0", done); else n_pass++;
      @(posedge clk); #1;
      wr_en = 1'b0;
      if (wr_phase == 2) begin
         wr_en = 1'b1; wr_addr = waddr; wr_data = wdata;
      end
      @(negedge clk);
      n_checks++; if (alu_valA !== a) $display("[TB] FAIL alu_valA: got %h want %h", alu_valA, a); else n_pass++;
      n_checks++; if (alu_valB !== b) $display("[TB] FAIL alu_valB: got %h want %h", alu_valB, b); else n_pass++;
      n_checks++; if (alu_aluop !== ins[19:16]) $display("[TB] FAIL alu_aluop: got %h want %h", alu_aluop, ins[19:16]); else n_pass++;
      n_checks++; if (alu_shift !== ins[6:3]) $display("[TB] FAIL alu_shift: got %b want %b", alu_shift, ins[6:3]); else n_pass++;
      n_checks++; if ({alu_sub, alu_lr} !== ins[2:1]) $display("[TB] FAIL alu_sub_lr: got %b want %b", {alu_sub, alu_lr}, ins[2:1]); else n_pass++;
      n_checks++; if (instr_ready !== 1'b0) $display("[TB] FAIL ready_capture: got %0b want 0", instr_ready); else n_pass++;
      @(posedge clk); #1;
      wr_en = 1'b0;
      if (wr_phase == 2 && !(ins[0] && waddr == ins[15:13])) mregs[waddr] = wdata;
      @(negedge clk);
      n_checks++; if (done !== 1'b1) $display("[TB] FAIL done_pulse: got %0b want 1", done); else n_pass++;
      n_checks++; if (instr_ready !== 1'b1) $display("[TB] FAIL ready_after: got %0b want 1", instr_ready); else n_pass++;
      #2;
      rd_addr = ins[15:13];
      #1;
      n_checks++; if (rd_data !== mregs[ins[15:13]]) $display("[TB] FAIL reg_rd r%0d: got %h want %h", ins[15:13], rd_data, mregs[ins[15:13]]); else n_pass++;
      if (wr_phase == 2) begin
         rd_addr = waddr;
         #1;
         n_checks++; if (rd_data !== mregs[waddr]) $display("[TB] FAIL reg_wr r%0d: got %h want %h", waddr, rd_data, mregs[waddr]); else n_pass++;
      end
      @(negedge clk);
      n_checks++; if (done !== 1'b0) $display("[TB] FAIL done_width: got %0b want 0", done); else n_pass++;
      @(posedge clk); #1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; instr_valid = 1'b0; instr = '0;
      wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
      for (int i = 0; i < 8; i++) mregs[i] = 16'h0000;
      repeat (2) @(posedge clk);
      #1;
      n_checks++; if (instr_ready !== 1'b1) $display("[TB] FAIL por_ready: got %0b want 1", instr_ready); else n_pass++;
      n_checks++; if (done !== 1'b0) $display("[TB] FAIL por_done: got %0b want 0", done); else n_pass++;
      n_checks++; if (cc_q !== 4'h0) $display("[TB] FAIL por_cc_q: got %h want 0", cc_q); else n_pass++;
      n_checks++; if ({alu_valA, alu_valB, alu_aluop, alu_shift, alu_sub, alu_lr} !== 42'h0)
         $display("[TB] FAIL por_alu: got %h want 0", {alu_valA, alu_valB, alu_aluop, alu_shift, alu_sub, alu_lr}); else n_pass++;
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         rd_addr = 3'(i);
         #1;
         n_checks++; if (rd_data !== 16'h0000) $display("[TB] FAIL por_reg r%0d: got %h want 0000", i, rd_data); else n_pass++;
      end
      @(posedge clk); #1;
   endtask

   task automatic test_add;
      write_reg(3'd1, 16'h9249);
      write_reg(3'd2, 16'h8888);
      run_instr(mk(4'd0, 3'd3, 3'd1, 3'd2, 4'd0, 1'b0, 1'b0, 1'b1), 0, 3'd0, 16'h0);
      rd_addr = 3'd3;
      #1;
      n_checks++; if (rd_data !== 16'h1AD1) $display("[TB] FAIL add_r3: got %h want 1ad1", rd_data); else n_pass++;
      n_checks++; if (cc_q !== 4'b0011) $display("[TB] FAIL add_cc: got %b want 0011", cc_q); else n_pass++;
      n_checks++; if (alu_valA !== 16'h9249 || alu_valB !== 16'h8888)
         $display("[TB] FAIL add_ops: got %h/%h want 9249/8888", alu_valA, alu_valB); else n_pass++;
      @(posedge clk); #1;
   endtask

   task automatic test_shift;
      run_instr(mk(4'd2, 3'd4, 3'd1, 3'd2, 4'b1000, 1'b0, 1'b1, 1'b1), 0, 3'd0, 16'h0);
      rd_addr = 3'd4;
      #1;
      n_checks++; if (alu_shift !== 4'b1000 || alu_lr !== 1'b1) $display("[TB] FAIL shl_fields: got %b/%b want 1000/1", alu_shift, alu_lr); else n_pass++;
      n_checks++; if (rd_data !== 16'h4900) $display("[TB] FAIL shl_r4: got %h want 4900", rd_data); else n_pass++;
      @(posedge clk); #1;
      run_instr(mk(4'd2, 3'd5, 3'd1, 3'd2, 4'b1000, 1'b0, 1'b0, 1'b1), 0, 3'd0, 16'h0);
      rd_addr = 3'd5;
      #1;
      n_checks++; if (alu_lr !== 1'b0) $display("[TB] FAIL shr_lr: got %b want 0", alu_lr); else n_pass++;
      n_checks++; if (rd_data !== 16'h0092) $display("[TB] FAIL shr_r5: got %h want 0092", rd_data); else n_pass++;
      @(posedge clk); #1;
   endtask

   task automatic test_compare;
      run_instr(mk(4'd0, 3'd3, 3'd2, 3'd1, 4'd0, 1'b1, 1'b0, 1'b0), 0, 3'd0, 16'h0);
      rd_addr = 3'd3;
      #1;
      n_checks++; if (rd_data !== 16'h1AD1) $display("[TB] FAIL cmp_r3: got %h want 1ad1", rd_data); else n_pass++;
      n_checks++; if (cc_q !== 4'b1000) $display("[TB] FAIL cmp_cc: got %b want 1000", cc_q); else n_pass++;
      @(posedge clk); #1;
   endtask

   task automatic test_collisions;
      run_instr(mk(4'd0, 3'd4, 3'd1, 3'd2, 4'd0, 1'b0, 1'b0, 1'b1), 1, 3'd1, 16'h0001);
      rd_addr = 3'd4;
      #1;
      n_checks++; if (alu_valA !== 16'h0001) $display("[TB] FAIL fwd_valA: got %h want 0001", alu_valA); else n_pass++;
      n_checks++; if (rd_data !== 16'h8889) $display("[TB] FAIL fwd_r4: got %h want 8889", rd_data); else n_pass++;
      @(posedge clk); #1;
      run_instr(mk(4'd1, 3'd5, 3'd2, 3'd2, 4'd0, 1'b0, 1'b0, 1'b1), 2, 3'd5, 16'hDEAD);
      rd_addr = 3'd5;
      #1;
      n_checks++; if (rd_data !== 16'h8888) $display("[TB] FAIL wb_wins_r5: got %h want 8888", rd_data); else n_pass++;
      @(posedge clk); #1;
      run_instr(mk(4'd3, 3'd5, 3'd1, 3'd2, 4'd0, 1'b0, 1'b0, 1'b1), 2, 3'd6, 16'hBEEF);
      rd_addr = 3'd6;
      #1;
      n_checks++; if (rd_data !== 16'hBEEF) $display("[TB] FAIL other_wr_r6: got %h want beef", rd_data); else n_pass++;
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back;
      logic [19:0] prog [4];
      int          acc_cyc [4];
      int          n_acc;
      int          start_done;
      int          budget;
      logic        acc;
      logic [19:0] e;
      exp_t        x;
      prog[0] = mk(4'd7,  3'd4, 3'd1, 3'd2, 4'd0, 1'b0, 1'b0, 1'b1);
      prog[1] = mk(4'd8,  3'd5, 3'd4, 3'd1, 4'd0, 1'b0, 1'b0, 1'b1);
      prog[2] = mk(4'd9,  3'd6, 3'd5, 3'd4, 4'd0, 1'b0, 1'b0, 1'b1);
      prog[3] = mk(4'd10, 3'd7, 3'd6, 3'd5, 4'd0, 1'b0, 1'b0, 1'b1);
      start_done = done_count;
      n_acc = 0;
      budget = 0;
      instr_valid = 1'b1;
      instr = prog[0];
      while (n_acc < 4 && budget < 40) begin
         @(negedge clk);
         acc = instr_ready && instr_valid;
         @(posedge clk); #1;
         budget++;
         if (acc) begin
            e = alu_fn(prog[n_acc][19:16], mregs[prog[n_acc][12:10]], mregs[prog[n_acc][9:7]],
                       prog[n_acc][6:3], prog[n_acc][2], prog[n_acc][1]);
            x.rd = prog[n_acc][15:13]; x.wb = 1'b1; x.res = e[15:0]; x.cc = e[19:16];
            sb.push_back(x);
            acc_cyc[n_acc] = cyc;
            n_acc++;
            if (n_acc < 4) instr = prog[n_acc];
            else instr_valid = 1'b0;
         end
      end
      instr_valid = 1'b0;
      budget = 0;
      while ((done_count - start_done) < 4 && budget < 20) begin
         @(posedge clk); #1;
         budget++;
      end
      n_checks++; if (n_acc !== 4) $display("[TB] FAIL b2b_accepts: got %0d want 4", n_acc); else n_pass++;
      n_checks++; if ((done_count - start_done) !== 4) $display("[TB] FAIL b2b_dones: got %0d want 4", done_count - start_done); else n_pass++;
      for (int i = 1; i < n_acc; i++) begin
         n_checks++; if ((acc_cyc[i] - acc_cyc[i-1]) !== 3) $display("[TB] FAIL b2b_spacing %0d: got %0d want 3", i, acc_cyc[i] - acc_cyc[i-1]); else n_pass++;
      end
      for (int i = 4; i < 8; i++) begin
         rd_addr = 3'(i);
         #1;
         n_checks++; if (rd_data !== mregs[i]) $display("[TB] FAIL b2b_r%0d: got %h want %h", i, rd_data, mregs[i]); else n_pass++;
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid;
      int done_before;
      run_instr(mk(4'd3, 3'd3, 3'd1, 3'd2, 4'd5, 1'b1, 1'b1, 1'b1), 0, 3'd0, 16'h0);
      instr_valid = 1'b1;
      instr = mk(4'd0, 3'd2, 3'd1, 3'd2, 4'd0, 1'b0, 1'b0, 1'b1);
      @(posedge clk); #1;
      instr_valid = 1'b0;
      done_before = done_count;
      #2;
      rst_n = 1'b0;
      #1;
      sb.delete();
      for (int i = 0; i < 8; i++) mregs[i] = 16'h0000;
      n_checks++; if (instr_ready !== 1'b1) $display("[TB] FAIL rst_ready: got %0b want 1", instr_ready); else n_pass++;
      n_checks++; if (done !== 1'b0) $display("[TB] FAIL rst_done: got %0b want 0", done); else n_pass++;
      n_checks++; if (cc_q !== 4'h0) $display("[TB] FAIL rst_cc_q: got %h want 0", cc_q); else n_pass++;
      n_checks++; if ({alu_valA, alu_valB, alu_aluop, alu_shift, alu_sub, alu_lr} !== 42'h0)
         $display("[TB] FAIL rst_alu: got %h want 0", {alu_valA, alu_valB, alu_aluop, alu_shift, alu_sub, alu_lr}); else n_pass++;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         rd_addr = 3'(i);
         #1;
         n_checks++; if (rd_data !== 16'h0000) $display("[TB] FAIL rst_reg r%0d: got %h want 0000", i, rd_data); else n_pass++;
      end
      repeat (2) @(posedge clk);
      #1;
      n_checks++; if (done_count !== done_before) $display("[TB] FAIL rst_no_done: got %0d want %0d", done_count, done_before); else n_pass++;
      write_reg(3'd0, 16'h1234);
      run_instr(mk(4'd0, 3'd1, 3'd0, 3'd0, 4'd0, 1'b0, 1'b0, 1'b1), 0, 3'd0, 16'h0);
      rd_addr = 3'd1;
      #1;
      n_checks++; if (rd_data !== 16'h2468) $display("[TB] FAIL post_rst_r1: got %h want 2468", rd_data); else n_pass++;
      @(posedge clk); #1;
   endtask

   initial begin
      test_reset();
      test_add();
      test_shift();
      test_compare();
      test_collisions();
      test_back_to_back();
      test_reset_mid();
      n_checks++; if (sb.size() !== 0) $display("[TB] FAIL sb_drained: got %0d want 0", sb.size()); else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/alu_issue_seq.md
# alu_issue_seq

Sequential front-end for the team's combinational ALU. It accepts 20-bit ALU instructions over a valid/ready handshake and reads both operands from an internal 8x16 register file. It then drives the ALU input ports from registers, captures the ALU `result` and `cc`, and writes the result back. It sits between the instruction source (bench or future decode stage) and the ALU, which it instantiates externally through its `alu_*` ports.

## Interface
- `NREG`, 8: register-file depth; fixed at 8 because address fields are 3 bits.
- `W`, 16: datapath width; matches the ALU `valA`/`valB`/`result` width.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `instr_valid` input 1: instruction offered.
- `instr` input 20: instruction word, `[19:16]` aluop, `[15:13]` rd, `[12:10]` ra, `[9:7]` rb, `[6:3]` shift, `[2]` sub, `[1]` lr, `[0]` wb_en.
- `instr_ready` output 1: block can accept an instruction.
- `wr_en` input 1: external register-file write strobe.
- `wr_addr` input 3: external write address.
- `wr_data` input 16: external write data.
- `rd_addr` input 3: debug read address.
- `rd_data` output 16: combinational register-file read of `rd_addr`.
- `alu_valA`, `alu_valB` output 16 each: registered ALU operands.
- `alu_aluop` output 4: registered ALU opcode.
- `alu_shift` output 4: registered shift amount.
- `alu_sub`, `alu_lr` output 1 each: registered ALU control bits.
- `alu_result` input 16: ALU result (combinational from the `alu_*` outputs).
- `alu_cc` input 4: ALU condition codes.
- `cc_q` output 4: last captured condition codes.
- `done` output 1: one-cycle pulse per completed instruction.

## Operation
- The state machine has three states: `IDLE`, `ISSUE` and `CAPTURE`. Reset enters `IDLE`.
- `IDLE`
  - `instr_ready` = 1.
  - On `instr_valid && instr_ready`, latch `instr` into an internal instruction register and go to `ISSUE`.
- `ISSUE`
  - `instr_ready` = 0.
  - Read `regs[ra]` and `regs[rb]`; the read includes any external write completing this edge (see Timing).
  - At the edge, load `alu_valA`, `alu_valB`, `alu_aluop`, `alu_shift`, `alu_sub` and `alu_lr` from the instruction and the operands. Go to `CAPTURE`.
- `CAPTURE`
  - `instr_ready` = 0.
  - At the edge, set `cc_q` <= `alu_cc`.
  - If `wb_en`, set `regs[rd]` <= `alu_result`.
  - Set `done` <= 1 and go to `IDLE`.
- `done` is registered; it is high only during the first `IDLE` cycle after `CAPTURE`.
- With `wb_en` = 0 the instruction is compare-only: `cc_q` updates, no register is written, and `done` still pulses.
- `alu_*` outputs hold their values between instructions; they change only at the `ISSUE` edge.
- The register file has no hardwired-zero register; r0 is a general register.

## Timing
- Accept edge E0; `alu_*` valid after E1; writeback, `cc_q` update and `done` rise at E2.
- `instr_ready` returns to 1 in the cycle after E2.
- Throughput is 1 instruction per 3 cycles.
- A new instruction may be accepted in the same cycle `done` is high.
- Reset values, asserted asynchronously on `rst_n` low:
  - state = `IDLE`, `instr_ready` = 1, `done` = 0, `cc_q` = 0.
  - All `alu_*` outputs = 0.
  - All registers = 0x0000.
- Reset mid-operation:
  - The in-flight instruction is discarded with no writeback and no `done`.
  - After `rst_n` rises, the first edge sees `IDLE`.
- External write (`wr_en`) is accepted in any state.
  - During `ISSUE`, a write to `ra` or `rb` in the same cycle is forwarded: the new `wr_data` is used as the operand.
  - During `CAPTURE`, if `wb_en` and `wr_addr` == rd, the ALU writeback wins and the external write is dropped.
  - A write to any other address always completes.
- The `instr_valid` handshake:
  - `instr` is sampled only on the accept edge.
  - `instr_valid` while `instr_ready` = 0 is ignored; the source must hold `instr_valid` until accepted.
- `rd_data` is purely combinational, showing register contents as of the last edge. It has no forwarding.
- Result width is 16 bits; the ALU carry-out is visible only through `cc`, and this block applies no extension or truncation.

## Test plan
- **Reset:** assert `rst_n` = 0 mid-`ISSUE`.
  - During reset: `instr_ready` = 1, `done` = 0, `cc_q` = 0, all `alu_*` outputs = 0.
  - After reset: `rd_data` reads 0x0000 for addresses 0–7.
- **Add with writeback:** write r1 = 0x9249 and r2 = 0x8888. Issue aluop 0000, rd 3, ra 1, rb 2, sub 0, wb_en 1.
  - After E1: `alu_valA` = 0x9249, `alu_valB` = 0x8888.
  - At E2: r3 = 0x1AD1, `cc_q` equals the ALU `cc`, `done` pulses for exactly 1 cycle, and `instr_ready` is low for exactly 2 cycles.
- **Shift fields:** issue aluop 0010, shift 1000, lr 1, then lr 0.
  - After E1: `alu_shift` = 4'b1000 and `alu_lr` follows the instruction.
  - rd receives the ALU result for each instruction.
- **Compare-only:** issue with wb_en 0 and rd 3 holding 0x1AD1.
  - r3 stays 0x1AD1, `cc_q` updates, `done` pulses.
- **Write collisions:**
  - `wr_en` to r1 = 0x0001 during `ISSUE` of an instruction with ra 1: `alu_valA` = 0x0001.
  - `wr_en` to rd during `CAPTURE` with wb_en 1: rd holds `alu_result`, not `wr_data`.
- **Back-to-back:** hold `instr_valid` = 1 with 4 queued instructions (aluop 0111–1010).
  - Accepts occur every 3 cycles, `done` pulses 4 times, and every instruction completes with no skipped or duplicated accept.
